// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Largest image, in 32-bit words, that fits in a memory of mem_bytes bytes.
  function automatic logic [15:0] max_words(input int mem_bytes);
    return 16'(mem_bytes / 4);
  endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Memory write port and CPU/status signals driven by the program loader.
interface uart_program_loader_if;

  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  modport master (
    output mem_address,
    output mem_write_en,
    output mem_write_data,
    output cpu_hold,
    output load_done,
    output load_error
  );

  modport slave (
    input mem_address,
    input mem_write_en,
    input mem_write_data,
    input cpu_hold,
    input load_done,
    input load_error
  );

endinterface

// File: rtl/uart_program_loader_uart_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, mid-bit sampling via a down-counting bit timer.
//
//  state    | meaning
//  ---------+-------------------------------------------------------
//  RX_IDLE  | line idle, waiting for a falling edge
//  RX_START | half-bit wait, start bit must still be low to proceed
//  RX_DATA  | sampling 8 data bits LSB first at bit centres
//  RX_STOP  | sampling stop bit; high -> valid, low -> frame_err
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int          TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

  rx_state_t     state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt, err_nxt;
  logic          rx_s1, rx_s2, rx_prev;

  // Synchronizer resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RX_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    data_nxt    = data;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          state_nxt = RX_START;
          timer_nxt = HALF;
        end
      end
      RX_START: begin
        if (timer == '0) begin
          if (!rx_s2) begin
            state_nxt   = RX_DATA;
            timer_nxt   = FULL;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = RX_IDLE;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      RX_DATA: begin
        if (timer == '0) begin
          shreg_nxt = {rx_s2, shreg[7:1]};
          timer_nxt = FULL;
          if (bit_cnt == 3'd7) begin
            state_nxt = RX_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      RX_STOP: begin
        if (timer == '0) begin
          state_nxt = RX_IDLE;
          if (rx_s2) begin
            valid_nxt = 1'b1;
            data_nxt  = shreg;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_program_loader.sv
// Serial program loader: receives a framed image over UART and writes it into CPU memory.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  ST_IDLE   | no frame seen since reset, waiting for SYNC
//  ST_LEN_LO | SYNC seen, expecting low byte of word count
//  ST_LEN_HI | expecting high byte of word count, range check
//  ST_DATA   | assembling little-endian words, one write per 4 bytes
//  ST_CSUM   | comparing received byte with XOR of data bytes
//  ST_DONE   | frame loaded, CPU released, waiting for next SYNC
//  ST_ERROR  | frame aborted, CPU held, waiting for next SYNC
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          MEM_BYTES    = 800,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RxD,
  uart_program_loader_if.master        mem_bus
);

  logic [7:0]    rx_data;
  logic          rx_valid, rx_err;

  loader_state_t state, state_nxt;
  logic [7:0]    len_lo;
  logic [15:0]   len, len_rx;
  logic [15:0]   word_cnt;
  logic [1:0]    byte_idx;
  logic [23:0]   word_shift;
  logic [7:0]    csum;
  logic [31:0]   mem_address, mem_write_data;
  logic          mem_write_en, cpu_hold, load_done, load_error;

  logic          start_frame, load_len_lo, start_data, accept_byte;
  logic          wr_word, set_done, set_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (RxD),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_err)
  );

  assign len_rx = {rx_data, len_lo};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    load_len_lo = 1'b0;
    start_data  = 1'b0;
    accept_byte = 1'b0;
    wr_word     = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    if (rx_err && (state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM})) begin
      state_nxt = ST_ERROR;
      set_err   = 1'b1;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_nxt   = ST_LEN_LO;
            start_frame = 1'b1;
          end
        end
        ST_LEN_LO: begin
          state_nxt   = ST_LEN_HI;
          load_len_lo = 1'b1;
        end
        ST_LEN_HI: begin
          if (len_rx > max_words(MEM_BYTES)) begin
            state_nxt = ST_ERROR;
            set_err   = 1'b1;
          end else if (len_rx == 16'd0) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt  = ST_DATA;
            start_data = 1'b1;
          end
        end
        ST_DATA: begin
          accept_byte = 1'b1;
          if (byte_idx == 2'd3) begin
            wr_word = 1'b1;
            if (word_cnt == len - 16'd1) state_nxt = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_data == csum) begin
            state_nxt = ST_DONE;
            set_done  = 1'b1;
          end else begin
            state_nxt = ST_ERROR;
            set_err   = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // The word is written straight from the 4th byte so a partial word never reaches memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo         <= '0;
      len            <= '0;
      word_cnt       <= '0;
      byte_idx       <= '0;
      word_shift     <= '0;
      csum           <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write_en   <= 1'b0;
      cpu_hold       <= 1'b0;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      mem_write_en <= wr_word;
      if (wr_word) mem_write_data <= {rx_data, word_shift};
      if (mem_write_en) begin
        mem_address <= mem_address + 32'd4;
        word_cnt    <= word_cnt + 16'd1;
      end
      if (load_len_lo) len_lo <= rx_data;
      if (start_frame) begin
        cpu_hold   <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        csum       <= '0;
        byte_idx   <= '0;
      end
      if (start_data) begin
        len         <= len_rx;
        mem_address <= BASE_ADDR;
        word_cnt    <= '0;
        byte_idx    <= '0;
      end
      if (accept_byte) begin
        csum     <= csum ^ rx_data;
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_shift[7:0]   <= rx_data;
          2'd1:    word_shift[15:8]  <= rx_data;
          2'd2:    word_shift[23:16] <= rx_data;
          default: ;
        endcase
      end
      if (set_done) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end
      if (set_err) load_error <= 1'b1;
    end
  end

  assign mem_bus.mem_address    = mem_address;
  assign mem_bus.mem_write_en   = mem_write_en;
  assign mem_bus.mem_write_data = mem_write_data;
  assign mem_bus.cpu_hold       = cpu_hold;
  assign mem_bus.load_done      = load_done;
  assign mem_bus.load_error     = load_error;

endmodule
